// File: rtl/axi_stream_combiner_rr_if.sv
// ---------------------------------------------------------------------------
// Interface : axi_stream
// AXI-stream bundle (data, dest, user, tlast, valid, ready) with master/slave views.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface axi_stream #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] data;
  logic [7:0]            dest;
  logic [7:0]            user;
  logic                  tlast;
  logic                  valid;
  logic                  ready;

  modport master (output data, dest, user, tlast, valid, input  ready);
  modport slave  (input  data, dest, user, tlast, valid, output ready);
endinterface

`default_nettype wire

// File: rtl/axi_stream_combiner_rr.sv
// ---------------------------------------------------------------------------
// Module : axi_stream_combiner_rr
// N-input AXI-stream merger, round-robin arbitration, registered output stage.
// Optional macro AXIS_COMBINER_TLAST_GEN_EN: per-channel tlast generation.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module axi_stream_combiner_rr #(
  parameter int    N_STREAMS         = 6,
  parameter int    INPUT_DATA_WIDTH  = 16,
  parameter int    OUTPUT_DATA_WIDTH = 32,
  parameter int    TLAST_PERIOD      = 1024,
  parameter string MSB_DEST_SUPPORT  = "TRUE"
) (
  input  logic     clock,
  input  logic     reset,
  axi_stream.slave  stream_in [N_STREAMS],
  axi_stream.master stream_out
);

  localparam int c_IDX_W    = (N_STREAMS > 1) ? $clog2(N_STREAMS) : 1;
  localparam bit c_MSB_DEST = (MSB_DEST_SUPPORT == "TRUE");

  logic [INPUT_DATA_WIDTH-1:0]  w_in_data [N_STREAMS];
  logic [7:0]                   w_in_dest [N_STREAMS];
  logic [7:0]                   w_in_user [N_STREAMS];
  logic [N_STREAMS-1:0]         w_in_valid;
  logic [N_STREAMS-1:0]         w_in_last;
  logic [N_STREAMS-1:0]         w_in_ready;

  logic                         r_valid;
  logic [OUTPUT_DATA_WIDTH-1:0] r_data;
  logic [7:0]                   r_dest;
  logic [7:0]                   r_user;
  logic                         r_last;
  logic [c_IDX_W-1:0]           r_last_grant;

  logic                         w_load_en;
  logic                         w_found;
  logic                         w_accept;
  logic [c_IDX_W-1:0]           w_grant;
  logic [c_IDX_W-1:0]           w_idx;
  logic [INPUT_DATA_WIDTH-1:0]  w_sel_data;
  logic [7:0]                   w_sel_dest;
  logic [OUTPUT_DATA_WIDTH-1:0] w_sext;
  logic [OUTPUT_DATA_WIDTH-1:0] w_next_data;
  logic                         w_next_last;

  for (genvar i = 0; i < N_STREAMS; i++) begin : g_in
    assign w_in_data[i]       = stream_in[i].data;
    assign w_in_dest[i]       = stream_in[i].dest;
    assign w_in_user[i]       = stream_in[i].user;
    assign w_in_valid[i]      = stream_in[i].valid;
    assign w_in_last[i]       = stream_in[i].tlast;
    assign stream_in[i].ready = w_in_ready[i];
  end

  logic w_unused_user;
  always_comb begin
    w_unused_user = 1'b0;
    for (int i = 0; i < N_STREAMS; i++) w_unused_user = w_unused_user ^ (^w_in_user[i]);
  end

  assign w_load_en = ~r_valid | stream_out.ready;

  // Search starts just after the previous winner so every channel gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 1; k <= N_STREAMS; k++) begin
      w_idx = c_IDX_W'((int'(r_last_grant) + k) % N_STREAMS);
      if (!w_found && w_in_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  assign w_accept = w_found & w_load_en;

  // Readies are gated by reset so they drop asynchronously with the output register.
  always_comb begin
    w_in_ready = '0;
    if (reset && w_accept) w_in_ready[w_grant] = 1'b1;
  end

  assign w_sel_data = w_in_data[w_grant];
  assign w_sel_dest = w_in_dest[w_grant];
  assign w_sext     = OUTPUT_DATA_WIDTH'($signed(w_sel_data));

  if (c_MSB_DEST) begin : g_msb_dest
    logic [7:0] w_unused_sext;
    assign w_unused_sext = w_sext[OUTPUT_DATA_WIDTH-1:OUTPUT_DATA_WIDTH-8];
    assign w_next_data   = {w_sel_dest, w_sext[OUTPUT_DATA_WIDTH-9:0]};
  end else begin : g_no_dest
    assign w_next_data = w_sext;
  end

`ifdef AXIS_COMBINER_TLAST_GEN_EN
  logic [15:0]          r_cnt [N_STREAMS];
  logic                 w_gen_last;
  logic [N_STREAMS-1:0] w_unused_last;

  assign w_unused_last = w_in_last;
  assign w_gen_last    = (r_cnt[w_grant] == 16'(TLAST_PERIOD - 1));
  assign w_next_last   = w_gen_last;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_STREAMS; i++) r_cnt[i] <= '0;
    end else if (w_accept) begin
      r_cnt[w_grant] <= w_gen_last ? 16'd0 : r_cnt[w_grant] + 16'd1;
    end
  end
`else
  assign w_next_last = w_in_last[w_grant];
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_dest       <= '0;
      r_user       <= '0;
      r_last       <= 1'b0;
      r_last_grant <= c_IDX_W'(N_STREAMS - 1);
    end else if (w_load_en) begin
      r_valid <= w_found;
      if (w_found) begin
        r_data       <= w_next_data;
        r_dest       <= w_sel_dest;
        r_user       <= 8'(w_grant);
        r_last       <= w_next_last;
        r_last_grant <= w_grant;
      end
    end
  end

  assign stream_out.valid = r_valid;
  assign stream_out.data  = r_data;
  assign stream_out.dest  = r_dest;
  assign stream_out.user  = r_user;
  assign stream_out.tlast = r_last;

endmodule

`default_nettype wire

// File: tb/tb_axi_stream_combiner_rr.sv
// ---------------------------------------------------------------------------
// Module : tb_axi_stream_combiner_rr
// Directed self-checking bench for axi_stream_combiner_rr (N=6, 16->32, period 4).
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_axi_stream_combiner_rr;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  tb_valid = '0;
  logic [5:0]  tb_last  = '0;
  logic [5:0]  tb_ready;
  logic        tb_out_ready = 1'b1;
  logic [15:0] tb_data [6];
  logic [7:0]  tb_dest [6];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  axi_stream #(.DATA_WIDTH(16)) s_in [6] ();
  axi_stream #(.DATA_WIDTH(32)) s_out ();

  for (genvar i = 0; i < 6; i++) begin : g_tb_in
    assign s_in[i].data  = tb_data[i];
    assign s_in[i].dest  = tb_dest[i];
    assign s_in[i].user  = 8'h00;
    assign s_in[i].tlast = tb_last[i];
    assign s_in[i].valid = tb_valid[i];
    assign tb_ready[i]   = s_in[i].ready;
  end
  assign s_out.ready = tb_out_ready;

  axi_stream_combiner_rr #(
    .N_STREAMS        (6),
    .INPUT_DATA_WIDTH (16),
    .OUTPUT_DATA_WIDTH(32),
    .TLAST_PERIOD     (4),
    .MSB_DEST_SUPPORT ("TRUE")
  ) u_dut (
    .clock     (clock),
    .reset     (reset),
    .stream_in (s_in),
    .stream_out(s_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [2:0]  seq_ch [11];
  logic [10:0] exp_last;

  initial begin
    for (int i = 0; i < 6; i++) begin
      tb_data[i] = 16'h0100 + 16'(i);
      tb_dest[i] = 8'h10 + 8'(i);
    end
    tb_valid = 6'b111111;

    // Reset state, with every input already offering a beat
    repeat (2) @(negedge clock);
    chk("rst_valid", 32'(s_out.valid), 32'h0);
    chk("rst_data",  s_out.data,       32'h0);
    chk("rst_dest",  32'(s_out.dest),  32'h0);
    chk("rst_user",  32'(s_out.user),  32'h0);
    chk("rst_tlast", 32'(s_out.tlast), 32'h0);
    chk("rst_ready", 32'(tb_ready),    32'h0);
    reset = 1'b1;
    #1;
    chk("first_grant", 32'(tb_ready), 32'h01);

    // Fairness: grants 0..5,0..5 at one beat per clock
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      chk("rr_valid", 32'(s_out.valid), 32'h1);
      chk("rr_user",  32'(s_out.user),  32'(k % 6));
      chk("rr_data",  s_out.data, {8'h10 + 8'(k % 6), 8'h00, 16'h0100 + 16'(k % 6)});
    end

    // Asynchronous reset mid-stream
    #2 reset = 1'b0;
    #1;
    chk("async_valid", 32'(s_out.valid), 32'h0);
    chk("async_ready", 32'(tb_ready),    32'h0);
    chk("async_data",  s_out.data,       32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rerst_grant", 32'(tb_ready), 32'h01);
    tb_valid = '0;

    // Backpressure: ch2 beat held while out.ready=0, ch4 waiting
    @(negedge clock);
    tb_out_ready = 1'b0;
    tb_data[2]   = 16'h1234;
    tb_dest[2]   = 8'h22;
    tb_valid     = 6'b000100;
    @(posedge clock);
    #1;
    tb_valid = 6'b010000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("bp_valid", 32'(s_out.valid), 32'h1);
      chk("bp_data",  s_out.data,       32'h22001234);
      chk("bp_ready", 32'(tb_ready),    32'h0);
    end
    tb_out_ready = 1'b1;
    #1;
    chk("bp_rel_ready", 32'(tb_ready), 32'h10);
    @(posedge clock);
    #1;
    tb_valid = '0;
    @(negedge clock);
    chk("bp_next_user", 32'(s_out.user), 32'h4);
    chk("bp_next_data", s_out.data,      32'h14000104);
    @(negedge clock);
    chk("bp_drained", 32'(s_out.valid), 32'h0);

    // Sign extension with dest packed into the MSBs
    tb_data[3] = 16'h8001;
    tb_dest[3] = 8'h5A;
    tb_valid   = 6'b001000;
    @(posedge clock);
    #1;
    tb_valid = '0;
    @(negedge clock);
    chk("sx_data", s_out.data,       32'h5AFF8001);
    chk("sx_dest", 32'(s_out.dest),  32'h5A);
    chk("sx_user", 32'(s_out.user),  32'h3);

    // Fresh reset so tlast counters start from zero
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;

`ifdef AXIS_COMBINER_TLAST_GEN_EN
    seq_ch   = '{3'd1, 3'd4, 3'd1, 3'd4, 3'd1, 3'd4, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
    exp_last = 11'b100_0100_0000;
    tb_last  = 6'b010000;
    for (int k = 0; k <= 11; k++) begin
      @(negedge clock);
      if (k > 0) begin
        chk("tgen_user", 32'(s_out.user),  32'(seq_ch[k-1]));
        chk("tgen_last", 32'(s_out.tlast), 32'(exp_last[k-1]));
      end
      if (k < 11) tb_valid = 6'b000001 << seq_ch[k];
      else        tb_valid = '0;
    end
`else
    seq_ch   = '{3'd5, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    exp_last = 11'b000_0000_0001;
    @(negedge clock);
    tb_last  = 6'b100000;
    tb_valid = 6'b100000;
    @(negedge clock);
    chk("tl_user", 32'(s_out.user),  32'(seq_ch[0]));
    chk("tl_last", 32'(s_out.tlast), 32'(exp_last[0]));
    tb_last = 6'b000000;
    @(negedge clock);
    chk("tl_user2", 32'(s_out.user),  32'(seq_ch[1]));
    chk("tl_last2", 32'(s_out.tlast), 32'(exp_last[1]));
    tb_valid = '0;
    @(negedge clock);
    chk("tl_idle", 32'(s_out.valid), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
